// File: rtl/operand_sorter_if.sv
// rtl/operand_sorter_if.sv - operand pair in / ordered result out handshake bundle
interface operand_sorter_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
);
  localparam int LW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] divisible;
  logic [WIDTH-1:0] divider;
  logic             swapped;
  logic             equal;
  logic             zero_div;
  logic             neg;
  logic [LW-1:0]    level;

  modport master (
    output in_valid, A, B, out_ready,
    input  in_ready, out_valid, divisible, divider, swapped, equal, zero_div, neg, level
  );

  modport slave (
    input  in_valid, A, B, out_ready,
    output in_ready, out_valid, divisible, divider, swapped, equal, zero_div, neg, level
  );
endinterface

// File: rtl/operand_sorter.sv
// rtl/operand_sorter.sv - orders operand pairs by magnitude into a small result FIFO
module operand_sorter #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 2,
  parameter int SIGNED = 0
) (
  input logic             clk,
  input logic             res,
  operand_sorter_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0]    FULL = LW'(DEPTH);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  typedef struct packed {
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dvr;
    logic             sw;
    logic             eq;
    logic             zd;
    logic             ng;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [LW-1:0] r_level;

  logic [WIDTH-1:0] w_ma;
  logic [WIDTH-1:0] w_mb;
  logic             w_b_gt;
  logic             w_push;
  logic             w_pop;
  entry_t           w_new;
  entry_t           w_head;

  // Negation in WIDTH bits maps the most negative value onto 2^(WIDTH-1).
  always_comb begin
    w_ma = bus.A;
    w_mb = bus.B;
    if (SIGNED != 0) begin
      if (bus.A[WIDTH-1]) w_ma = ~bus.A + ONE;
      if (bus.B[WIDTH-1]) w_mb = ~bus.B + ONE;
    end
    w_b_gt    = (w_mb > w_ma);
    w_new     = '0;
    w_new.dvs = w_b_gt ? w_mb : w_ma;
    w_new.dvr = w_b_gt ? w_ma : w_mb;
    w_new.sw  = w_b_gt;
    w_new.eq  = (w_ma == w_mb);
    w_new.zd  = ((w_b_gt ? w_ma : w_mb) == '0);
    w_new.ng  = (SIGNED != 0) && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
  end

  assign w_push = bus.in_valid && bus.in_ready;
  assign w_pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_new;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop) r_rd <= r_rd + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end

  assign w_head        = r_mem[r_rd];
  assign bus.in_ready  = (r_level != FULL);
  assign bus.out_valid = (r_level != '0);
  assign bus.level     = r_level;
  assign bus.divisible = w_head.dvs;
  assign bus.divider   = w_head.dvr;
  assign bus.swapped   = w_head.sw;
  assign bus.equal     = w_head.eq;
  assign bus.zero_div  = w_head.zd;
  assign bus.neg       = w_head.ng;
endmodule

// File: doc/operand_sorter.md
# operand_sorter

Parametrised operand-ordering stage for the ALU divider datapath. Accepts operand pairs (A, B) over a valid/ready handshake and orders each pair into divisible (larger magnitude) and divider (smaller magnitude). Results are buffered in a DEPTH-entry FIFO and presented to the divider core over a second valid/ready handshake. Equal operands are forwarded with a flag, not discarded, and a signed-magnitude mode is supported.

## Interface
- WIDTH, 16: operand and result width in bits (≥2).
- DEPTH, 2: FIFO entries; power of two, ≥2.
- SIGNED, 0: 0 = operands unsigned; 1 = operands two's complement, ordered by magnitude.
- clk  input  1  clock, all state on rising edge.
- res  input  1  reset, asynchronous, active-low.
- in_valid  input  1  A/B pair valid.
- in_ready  output  1  stage can accept a pair.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- out_valid  output  1  head entry valid.
- out_ready  input  1  divider core accepts head entry.
- divisible  output  WIDTH  larger magnitude (unsigned).
- divider  output  WIDTH  smaller magnitude (unsigned).
- swapped  output  1  1 when |B| > |A|, i.e. operands were exchanged.
- equal  output  1  1 when |A| == |B|.
- zero_div  output  1  1 when divider == 0.
- neg  output  1  SIGNED=1: sign(A) XOR sign(B); SIGNED=0: always 0.
- level  output  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready. Push and pop in the same cycle are both performed; level is unchanged.
- in_ready = (level != DEPTH), taken from registered state only. No combinational path from out_ready to in_ready.
- out_valid = (level != 0). Output fields come from the head entry and remain stable while out_valid && !out_ready.
- Magnitude: SIGNED=0 uses mA = A, mB = B. SIGNED=1 uses mA = |A|, mB = |B|, computed in WIDTH bits unsigned. The most negative value maps to 2^(WIDTH-1) without overflow.
- Ordering: if mA ≥ mB, divisible = mA, divider = mB, swapped = 0. Otherwise divisible = mB, divider = mA, swapped = 1.
- equal = (mA == mB). Equal pairs are forwarded with divisible = divider = mA.
- zero_div = (divider == 0). Both-zero input gives divisible = 0, divider = 0, equal = 1, zero_div = 1.
- Flags are computed at push time and stored with the entry.
- Pointers wrap modulo DEPTH. A push while full is ignored because in_ready = 0. A pop while empty is ignored.

## Timing
- Reset (res = 0, asynchronous) clears all of the following:
  - read pointer, write pointer and level to 0;
  - all FIFO storage to 0;
  - outputs: in_ready = 1, out_valid = 0, divisible = 0, divider = 0, and all flags 0.
- Reset asserted mid-operation discards every buffered entry immediately. No partial entry survives.
- Latency: a pair pushed at edge k is visible with out_valid = 1 after edge k (cycle k+1) when the FIFO was empty. There is no combinational in→out bypass.
- Throughput: one pair per cycle sustained while out_ready = 1.
- Full: after DEPTH pushes without a pop, in_ready = 0 on the following cycle. A pop at edge j raises in_ready after edge j.
- Inputs are sampled only on accepted edges. A/B may change freely while in_valid = 0 or in_ready = 0.

## Test plan
- Reset/idle: hold res = 0, then release. Required: in_ready = 1, out_valid = 0, level = 0, all data outputs 0. Assert res mid-burst with level = 2: level = 0 and out_valid = 0 immediately.
- Unsigned ordering (WIDTH 16, SIGNED 0), out_ready = 1:
  - push (100, 7): divisible 100, divider 7, swapped 0.
  - push (7, 100): divisible 100, divider 7, swapped 1.
  - push (5, 5): equal 1, divisible 5, divider 5.
  - push (0, 9): divisible 9, divider 0, zero_div 1.
- Signed mode (SIGNED 1):
  - push (-20, 3), i.e. 0xFFEC, 0x0003: divisible 20, divider 3, neg 1.
  - push (0x8000, 0x7FFF): divisible 0x8000, divider 0x7FFF, swapped 0, neg 1.
- Backpressure (DEPTH 2): out_ready = 0 while pushing 3 pairs on consecutive cycles. Required: only the first 2 are accepted, in_ready drops after the second push, and level = 2. The head stays stable across idle cycles. Raise out_ready: the pairs drain in order, and in_ready = 1 after the first pop.
- Simultaneous push/pop: with level = 1, assert in_valid and out_ready together for 10 cycles with incrementing operands. Required: level stays 1, outputs follow in order with 1-cycle latency, and no entry is lost or duplicated.
- Wrap-around: stream 4×DEPTH pairs with random out_ready. Required: output order matches input order exactly across pointer wraps, and the scoreboard matches.
